// File: rtl/bilinear_scaler_stream.sv
// bilinear_scaler_stream
//   Fetches an SW x SH source window at (H0,V0) from a square image memory
//   and streams an N x N upscaled grid (N = 2^K+1) in raster order. The
//   interpolation is bilinear (MODE=0) or nearest-neighbour (MODE=1).
//   Memory reads go out one at a time on REN/ADDR. Output pixels use a
//   valid/ready handshake.
// Ports:
//   clk, RST            clock; asynchronous active-high reset
//   START, MODE         frame request (sampled while idle); mode latched with it
//   H0, V0, SW, SH      window origin and size (SW, SH legal 1..2^K)
//   REN, ADDR, R_DATA   memory read port; REN is active-low; data returns one cycle later
//   O_DATA, O_VALID     output pixel stream
//   O_READY             sink ready
//   BUSY, DONE          frame in progress; one-cycle end-of-frame pulse
module bilinear_scaler_stream #(
  parameter int DW       = 8,
  parameter int IMG_LOG2 = 6,
  parameter int K        = 4
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  MODE,
  input  logic [IMG_LOG2-1:0]   H0,
  input  logic [IMG_LOG2-1:0]   V0,
  input  logic [K:0]            SW,
  input  logic [K:0]            SH,
  output logic                  REN,
  output logic [2*IMG_LOG2-1:0] ADDR,
  input  logic [DW-1:0]         R_DATA,
  output logic [DW-1:0]         O_DATA,
  output logic                  O_VALID,
  input  logic                  O_READY,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int PW = 2*K+1;          // width of x*(SW-1)
  localparam int WW = DW+K+1;         // interpolation intermediate width
  localparam logic [K:0] SCALE = {1'b1, {K{1'b0}}};  // 2^K, also the last grid index
  localparam logic [K:0] ONE_K = {{K{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CALC  = 3'd2,
    S_OUT   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [IMG_LOG2-1:0]   h0_q, h0_d, v0_q, v0_d;
  logic [K:0]            sw_q, sw_d, sh_q, sh_d;
  logic [K:0]            x_q, x_d, y_q, y_d;
  logic [2:0]            iss_q, iss_d;
  logic                  ren_q, ren_d;
  logic [2*IMG_LOG2-1:0] addr_q, addr_d;
  logic [1:0]            rd_tag_q, rd_tag_d;
  logic                  cap_vld_q, cap_vld_d;
  logic [1:0]            cap_tag_q, cap_tag_d;
  logic [DW-1:0]         odata_q, odata_d;
  logic                  ovalid_q, ovalid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  // Slot index = {r, c}: 0 = P00, 1 = P10, 2 = P01, 3 = P11
  logic [DW-1:0]         pix_q [4];

  logic [PW-1:0]         px_s, py_s;
  logic [K:0]            ix_s, iy_s;
  logic [K-1:0]          fx_s, fy_s;
  logic [3:0]            need_s;
  logic [IMG_LOG2-1:0]   col_s, row_s;
  logic [WW-1:0]         wfx_s, wfy_s, l_sum_s, r_sum_s, b_sum_s;
  logic [DW-1:0]         l_s, r_s, bil_s, near_s;

  // Source coordinate of the current grid point and the reads it needs
  always_comb begin
    px_s      = PW'(x_q) * PW'(sw_q - ONE_K);
    py_s      = PW'(y_q) * PW'(sh_q - ONE_K);
    ix_s      = px_s[PW-1:K];
    iy_s      = py_s[PW-1:K];
    fx_s      = px_s[K-1:0];
    fy_s      = py_s[K-1:0];
    // A zero fraction gives the far neighbour zero weight, so it is not fetched
    need_s[0] = 1'b1;
    need_s[1] = |fx_s;
    need_s[2] = |fy_s;
    need_s[3] = (|fx_s) & (|fy_s);
    // Row and column wrap naturally through the IMG_LOG2-bit sums
    col_s     = h0_q + IMG_LOG2'(ix_s) + IMG_LOG2'(iss_q[0]);
    row_s     = v0_q + IMG_LOG2'(iy_s) + IMG_LOG2'(iss_q[1]);
  end

  // Bilinear and nearest-neighbour pixel values from the fetched neighbours
  always_comb begin
    wfx_s   = WW'(SCALE - {1'b0, fx_s});
    wfy_s   = WW'(SCALE - {1'b0, fy_s});
    l_sum_s = WW'(pix_q[0]) * wfy_s + WW'(pix_q[2]) * WW'(fy_s);
    r_sum_s = WW'(pix_q[1]) * wfy_s + WW'(pix_q[3]) * WW'(fy_s);
    l_s     = DW'(l_sum_s >> K);
    r_s     = DW'(r_sum_s >> K);
    b_sum_s = WW'(l_s) * wfx_s + WW'(r_s) * WW'(fx_s);
    bil_s   = DW'(b_sum_s >> K);
    near_s  = pix_q[{fy_s[K-1], fx_s[K-1]}];
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    h0_d      = h0_q;
    v0_d      = v0_q;
    sw_d      = sw_q;
    sh_d      = sh_q;
    x_d       = x_q;
    y_d       = y_q;
    iss_d     = iss_q;
    ren_d     = 1'b1;
    addr_d    = addr_q;
    rd_tag_d  = rd_tag_q;
    cap_vld_d = ~ren_q;
    cap_tag_d = rd_tag_q;
    odata_d   = odata_q;
    ovalid_d  = ovalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (START) begin
          mode_d  = MODE;
          h0_d    = H0;
          v0_d    = V0;
          sw_d    = SW;
          sh_d    = SH;
          x_d     = {(K+1){1'b0}};
          y_d     = {(K+1){1'b0}};
          iss_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        // Slots 0..3 are issued in iss 0..3; the last datum lands in iss 5
        iss_d = iss_q + 3'd1;
        if ((iss_q < 3'd4) && need_s[iss_q[1:0]]) begin
          ren_d    = 1'b0;
          addr_d   = {row_s, col_s};
          rd_tag_d = iss_q[1:0];
        end else begin
          ren_d    = 1'b1;
        end
        if (iss_q == 3'd5) begin
          iss_d   = 3'd0;
          state_d = S_CALC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_CALC: begin
        odata_d  = mode_q ? near_s : bil_s;
        ovalid_d = 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (O_READY) begin
          ovalid_d = 1'b0;
          if ((x_q == SCALE) && (y_q == SCALE)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else if (x_q == SCALE) begin
            x_d     = {(K+1){1'b0}};
            y_d     = y_q + ONE_K;
            state_d = S_FETCH;
          end else begin
            x_d     = x_q + ONE_K;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        busy_d   = 1'b0;
        ovalid_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      h0_q      <= {IMG_LOG2{1'b0}};
      v0_q      <= {IMG_LOG2{1'b0}};
      sw_q      <= {(K+1){1'b0}};
      sh_q      <= {(K+1){1'b0}};
      x_q       <= {(K+1){1'b0}};
      y_q       <= {(K+1){1'b0}};
      iss_q     <= 3'd0;
      ren_q     <= 1'b1;
      addr_q    <= {(2*IMG_LOG2){1'b0}};
      rd_tag_q  <= 2'd0;
      cap_vld_q <= 1'b0;
      cap_tag_q <= 2'd0;
      odata_q   <= {DW{1'b0}};
      ovalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      h0_q      <= h0_d;
      v0_q      <= v0_d;
      sw_q      <= sw_d;
      sh_q      <= sh_d;
      x_q       <= x_d;
      y_q       <= y_d;
      iss_q     <= iss_d;
      ren_q     <= ren_d;
      addr_q    <= addr_d;
      rd_tag_q  <= rd_tag_d;
      cap_vld_q <= cap_vld_d;
      cap_tag_q <= cap_tag_d;
      odata_q   <= odata_d;
      ovalid_q  <= ovalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Neighbour capture: R_DATA belongs to the read issued on the previous cycle
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) pix_q[i] <= {DW{1'b0}};
    end else if (cap_vld_q) begin
      pix_q[cap_tag_q] <= R_DATA;
    end
  end

  assign REN     = ren_q;
  assign ADDR    = addr_q;
  assign O_DATA  = odata_q;
  assign O_VALID = ovalid_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_bilinear_scaler_stream.sv
// tb_bilinear_scaler_stream
//   Directed bench for bilinear_scaler_stream (DW=8, IMG_LOG2=6, K=4).
//   A behavioural SRAM answers reads one cycle after REN=0. The expected
//   pixel values are closed-form results worked out by hand for each window.
module tb_bilinear_scaler_stream;

  logic        clk = 1'b0;
  logic        RST;
  logic        START;
  logic        MODE;
  logic [5:0]  H0, V0;
  logic [4:0]  SW, SH;
  logic        REN;
  logic [11:0] ADDR;
  logic [7:0]  R_DATA;
  logic [7:0]  O_DATA;
  logic        O_VALID;
  logic        O_READY;
  logic        BUSY;
  logic        DONE;

  logic [7:0]  mem [4096];
  logic [7:0]  got [289];
  int          n_checks = 0;
  int          n_errors = 0;

  // read monitors
  int rd_total = 0, rd_4095 = 0, rd_4032 = 0, rd_63 = 0, rd_0 = 0, rd_col6 = 0;

  bilinear_scaler_stream #(.DW(8), .IMG_LOG2(6), .K(4)) dut (
    .clk(clk), .RST(RST), .START(START), .MODE(MODE),
    .H0(H0), .V0(V0), .SW(SW), .SH(SH),
    .REN(REN), .ADDR(ADDR), .R_DATA(R_DATA),
    .O_DATA(O_DATA), .O_VALID(O_VALID), .O_READY(O_READY),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  // SRAM model: data for a read appears the cycle after REN=0
  always @(posedge clk) begin
    if (REN === 1'b0) R_DATA <= mem[ADDR];
  end

  // Read address monitor
  always @(posedge clk) begin
    if (REN === 1'b0) begin
      rd_total <= rd_total + 1;
      if (ADDR == 12'd4095) rd_4095 <= rd_4095 + 1;
      if (ADDR == 12'd4032) rd_4032 <= rd_4032 + 1;
      if (ADDR == 12'd63)   rd_63   <= rd_63 + 1;
      if (ADDR == 12'd0)    rd_0    <= rd_0 + 1;
      if (ADDR[5:0] == 6'd6) rd_col6 <= rd_col6 + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_px(input int kind, input int i);
    int x, y;
    x = i % 17;
    y = i / 17;
    case (kind)
      0:       return 10 * x;                 // horizontal ramp 0..160
      1:       return (x < 8) ? 0 : 160;      // nearest of the same window
      2:       return (255 * y) >> 4;         // vertical ramp 0..255
      default: return (200 * y) >> 4;        // SW=1, column of 0/100/200
    endcase
  endfunction

  // Step cycles, accepting pixels, until 'want' accepted or budget expires
  task automatic run_px(input int want, input int max_cyc, input int stall_at,
                        input int poke_at, output int n, output int dn);
    int cyc = 0;
    int sc = 0;
    logic [7:0] held = 8'd0;
    n = 0;
    dn = 0;
    while (n < want && cyc < max_cyc) begin
      if (cyc == poke_at) begin
        START = 1'b1;
        MODE  = ~MODE;
        SW    = 5'd1;
      end else begin
        START = 1'b0;
      end
      if (n == stall_at && (O_VALID || sc > 0) && sc < 5) begin
        O_READY = 1'b0;
        if (sc == 0) held = O_DATA;
        else begin
          check_eq("hold_data", O_DATA, held);
          check_eq("hold_valid", O_VALID, 1);
        end
        sc++;
      end else begin
        O_READY = 1'b1;
      end
      if (DONE) dn++;
      if (O_VALID && O_READY) begin
        got[n] = O_DATA;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    START = 1'b0;
    O_READY = 1'b1;
  endtask

  task automatic frame(input logic mode, input logic [5:0] h0, input logic [5:0] v0,
                       input logic [4:0] sw, input logic [4:0] sh,
                       input int kind, input int stall_at, input int poke_at);
    int n, dn, quiet;
    START = 1'b1; MODE = mode; H0 = h0; V0 = v0; SW = sw; SH = sh;
    @(posedge clk); #1;
    START = 1'b0;
    check_eq("busy_rise", BUSY, 1);
    run_px(289, 4000, stall_at, poke_at, n, dn);
    check_eq("px_count", n, 289);
    check_eq("early_done", dn, 0);
    check_eq("done_pulse", DONE, 1);
    check_eq("busy_fin", BUSY, 0);
    for (int i = 0; i < n; i++) check_eq("pixel", got[i], exp_px(kind, i));
    @(posedge clk); #1;
    check_eq("done_drop", DONE, 0);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      if (O_VALID || DONE || BUSY || !REN) quiet++;
      @(posedge clk); #1;
    end
    check_eq("idle_quiet", quiet, 0);
  endtask

  initial begin
    int n, dn, rd_before, quiet;
    RST = 1'b1; START = 1'b0; MODE = 1'b0; H0 = 6'd0; V0 = 6'd0;
    SW = 5'd2; SH = 5'd2; O_READY = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 8'hAA;
    mem[20*64+10] = 8'd0;   mem[20*64+11] = 8'd160;
    mem[21*64+10] = 8'd0;   mem[21*64+11] = 8'd160;
    mem[40*64+30] = 8'd0;   mem[40*64+31] = 8'd0;
    mem[41*64+30] = 8'd255; mem[41*64+31] = 8'd255;
    mem[50*64+5] = 8'd0;    mem[51*64+5] = 8'd100;  mem[52*64+5] = 8'd200;
    mem[50*64+6] = 8'd77;   mem[51*64+6] = 8'd77;   mem[52*64+6] = 8'd77;
    mem[4095] = 8'd16; mem[4032] = 8'd32; mem[63] = 8'd48; mem[0] = 8'd64;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ren", REN, 1);
    check_eq("rst_addr", ADDR, 0);
    check_eq("rst_odata", O_DATA, 0);
    check_eq("rst_ovalid", O_VALID, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_done", DONE, 0);
    RST = 1'b0;
    @(posedge clk); #1;

    // horizontal ramp, with an ignored START part way through
    frame(1'b0, 6'd10, 6'd20, 5'd2, 5'd2, 0, -1, 40);
    // nearest on the same window
    frame(1'b1, 6'd10, 6'd20, 5'd2, 5'd2, 1, -1, -1);
    // vertical ramp
    frame(1'b0, 6'd30, 6'd40, 5'd2, 5'd2, 2, -1, -1);
    // single-column window must never touch column H0+1
    frame(1'b0, 6'd5, 6'd50, 5'd1, 5'd3, 3, -1, -1);
    check_eq("col_h0p1", rd_col6, 0);
    // back-pressure on pixel 3
    frame(1'b0, 6'd10, 6'd20, 5'd2, 5'd2, 0, 3, -1);

    // wrapping window, aborted by reset mid-frame
    START = 1'b1; MODE = 1'b0; H0 = 6'd63; V0 = 6'd63; SW = 5'd2; SH = 5'd2;
    @(posedge clk); #1;
    START = 1'b0;
    run_px(19, 400, -1, -1, n, dn);
    check_eq("wrap_count", n, 19);
    check_eq("wrap_px0", got[0], 16);
    check_eq("wrap_px1", got[1], 17);
    check_eq("wrap_px17", got[17], 18);
    check_eq("wrap_px18", got[18], 19);
    check_eq("rd_4095", rd_4095 > 0, 1);
    check_eq("rd_4032", rd_4032 > 0, 1);
    check_eq("rd_63", rd_63 > 0, 1);
    check_eq("rd_0", rd_0 > 0, 1);
    check_eq("busy_pre", BUSY, 1);
    RST = 1'b1;
    #1;
    check_eq("abort_ren", REN, 1);
    check_eq("abort_ovalid", O_VALID, 0);
    check_eq("abort_busy", BUSY, 0);
    @(posedge clk); #1;
    RST = 1'b0;
    rd_before = rd_total;
    quiet = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (O_VALID || BUSY || DONE) quiet++;
    end
    check_eq("post_abort_quiet", quiet, 0);
    check_eq("post_abort_reads", rd_total - rd_before, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
